cpu_csr_access: RTL

- Pipeline-side initiator for the CSR file's read/write ports.
- Executes Zicsr instructions (CSRRW/RS/RC and the immediate forms) as a read-modify-write sequence and returns the old CSR value for writeback.
- Detects illegal CSR encodings and raises a synchronous trap through the CSR file's mtrap_i/mcause_i/trap_pc_i control port.
- Sits between execute and the CSR file and stalls the front of the pipeline via req_ready_o.

---
 rtl/cpu_csr_access_pkg.sv | 38 +++
 rtl/cpu_csr_access_alu.sv | 22 ++
 rtl/cpu_csr_access.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_csr_access_pkg.sv
// Shared types and helpers for the Zicsr access sequencer (cpu_csr_access).
package cpu_csr_access_pkg;

  typedef logic [11:0] csr_t;
  typedef logic [31:0] mcause_t;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_t;

  typedef enum logic [1:0] {
    CSR_ST_IDLE  = 2'd0,
    CSR_ST_READ  = 2'd1,
    CSR_ST_WRITE = 2'd2,
    CSR_ST_TRAP  = 2'd3
  } csr_access_state_t;

  localparam int unsigned EXC_ILLEGAL_INSTR = 32'd2;

  function automatic logic csr_is_rw(input logic [2:0] op);
    return (op == 3'(CSR_OP_RW)) || (op == 3'(CSR_OP_RWI));
  endfunction

  function automatic logic csr_funct3_illegal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b100);
  endfunction

  // Set/clear with a zero source are pure reads and must not write.
  function automatic logic csr_write_intended(input logic [2:0] op, input logic src_zero);
    return csr_is_rw(op) || !src_zero;
  endfunction

endpackage

// File: rtl/cpu_csr_access_alu.sv
// Combinational read-modify-write datapath: new CSR value from op, old value and source.
module cpu_csr_access_alu
  import cpu_csr_access_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_old,
  input  logic [31:0] i_src,
  output logic [31:0] o_new
);

  // Select write/set/clear result.
  always_comb begin
    o_new = i_old;
    case (i_op)
      3'(CSR_OP_RW), 3'(CSR_OP_RWI): o_new = i_src;
      3'(CSR_OP_RS), 3'(CSR_OP_RSI): o_new = i_old | i_src;
      3'(CSR_OP_RC), 3'(CSR_OP_RCI): o_new = i_old & ~i_src;
      default:                       o_new = i_old;
    endcase
  end

endmodule

// File: rtl/cpu_csr_access.sv
// Zicsr read-modify-write initiator toward the CSR file, with illegal-instruction trap.
// Optional: define CSR_RO_CHECK_EN to trap writes to read-only CSRs (addr[11:10]==2'b11).
module cpu_csr_access
  import cpu_csr_access_pkg::*;
#(
  parameter int unsigned EXC_ILLEGAL = EXC_ILLEGAL_INSTR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_src_i,
  input  logic        req_src_zero_i,
  input  logic        req_rd_zero_i,
  input  logic [31:0] req_pc_i,
  input  logic        flush_i,
  output logic [11:0] read_addr_o,
  output logic        read_enable_o,
  input  logic [31:0] read_data_i,
  output logic [11:0] write_addr_o,
  output logic [31:0] write_data_o,
  output logic        write_enable_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        mtrap_o,
  output logic [31:0] mcause_o,
  output logic [31:0] trap_pc_o
);

  localparam logic [1:0] ST_IDLE  = 2'(CSR_ST_IDLE);
  localparam logic [1:0] ST_READ  = 2'(CSR_ST_READ);
  localparam logic [1:0] ST_WRITE = 2'(CSR_ST_WRITE);
  localparam logic [1:0] ST_TRAP  = 2'(CSR_ST_TRAP);

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  csr_t        r_addr;
  logic [31:0] r_src;
  logic        r_src_zero;
  logic        r_rd_zero;
  logic [31:0] r_pc;

  logic        w_accept;
  logic        w_ro_illegal;
  logic        w_illegal;
  logic [1:0]  w_next_after_accept;
  logic        w_skip_read;
  logic        w_wr_intended;
  logic        w_ro_target;
  logic [31:0] w_old;
  logic [31:0] w_new;

  assign req_ready_o = (r_state == ST_IDLE) && !reset_i;
  assign w_accept    = req_valid_i && req_ready_o && !flush_i;

`ifdef CSR_RO_CHECK_EN
  assign w_ro_illegal = (req_addr_i[11:10] == 2'b11) && csr_write_intended(req_op_i, req_src_zero_i);
`else
  assign w_ro_illegal = 1'b0;
`endif

  assign w_illegal = csr_funct3_illegal(req_op_i) || w_ro_illegal;
  assign w_next_after_accept = w_illegal ? ST_TRAP :
                               (csr_is_rw(req_op_i) && req_rd_zero_i) ? ST_WRITE : ST_READ;

  assign w_skip_read   = csr_is_rw(r_op) && r_rd_zero;
  assign w_wr_intended = csr_write_intended(r_op, r_src_zero);
  // Read-only targets reach WRITE only when the trap check is compiled out; suppress the write.
  assign w_ro_target   = (r_addr[11:10] == 2'b11);
  assign w_old         = w_skip_read ? 32'h0000_0000 : read_data_i;

  cpu_csr_access_alu u_alu (
    .i_op  (r_op),
    .i_old (w_old),
    .i_src (r_src),
    .o_new (w_new)
  );

  // State sequencing and request capture.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_op       <= 3'b000;
      r_addr     <= 12'h000;
      r_src      <= 32'h0000_0000;
      r_src_zero <= 1'b0;
      r_rd_zero  <= 1'b0;
      r_pc       <= 32'h0000_0000;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= w_next_after_accept;
            r_op       <= req_op_i;
            r_addr     <= req_addr_i;
            r_src      <= req_src_i;
            r_src_zero <= req_src_zero_i;
            r_rd_zero  <= req_rd_zero_i;
            r_pc       <= req_pc_i;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ:  r_state <= ST_WRITE;
        ST_WRITE: r_state <= ST_IDLE;
        ST_TRAP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-state port drive; flush kills side effects in the same cycle.
  always_comb begin
    read_addr_o    = 12'h000;
    read_enable_o  = 1'b0;
    write_addr_o   = 12'h000;
    write_data_o   = 32'h0000_0000;
    write_enable_o = 1'b0;
    rsp_valid_o    = 1'b0;
    rsp_data_o     = 32'h0000_0000;
    mtrap_o        = 1'b0;
    mcause_o       = 32'h0000_0000;
    trap_pc_o      = 32'h0000_0000;
    case (r_state)
      ST_READ: begin
        read_enable_o = 1'b1;
        read_addr_o   = r_addr;
      end
      ST_WRITE: begin
        write_addr_o   = r_addr;
        write_data_o   = w_new;
        write_enable_o = w_wr_intended && !w_ro_target && !flush_i;
        rsp_valid_o    = !flush_i;
        rsp_data_o     = w_old;
      end
      ST_TRAP: begin
        mtrap_o   = !flush_i;
        mcause_o  = {1'b0, 31'(EXC_ILLEGAL)};
        trap_pc_o = r_pc;
      end
      default: begin
        read_enable_o = 1'b0;
      end
    endcase
  end

endmodule
